// File: rtl/dbg_bus_bridge.sv
// rtl/dbg_bus_bridge.sv - Debug-module to core-bus access bridge with grant timeout and overflow flag
module dbg_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dbg_req_valid_i,
    output logic        dbg_req_ready_o,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_rsp_valid_o,
    output logic [31:0] dbg_rsp_rdata_o,
    output logic        dbg_rsp_err_o,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    output logic        ovf_o,
    input  logic        ovf_clr_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        ovf_q;

    logic        accept;
    logic        rsp_load;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        rsp_load  = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        case (state_q)
            IDLE: begin
                if (dbg_req_valid_i) begin
                    accept = 1'b1;
                    // Misaligned accesses are answered locally without touching the bus
                    if (dbg_addr_i[1:0] != 2'b00) begin
                        state_d  = RESP;
                        rsp_load = 1'b1;
                        rsp_err  = 1'b1;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                // Grant is checked first so a grant in the final wait cycle still wins
                if (bus_gnt_i) begin
                    state_d   = RESP;
                    rsp_load  = 1'b1;
                    rsp_rdata = we_q ? 32'h0 : bus_rdata_i;
                end else if (cnt_q == TMO_LAST) begin
                    state_d  = RESP;
                    rsp_load = 1'b1;
                    rsp_err  = 1'b1;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= dbg_we_i;
                addr_q  <= dbg_addr_i;
                wdata_q <= dbg_wdata_i;
            end
            if (rsp_load) begin
                rdata_q <= rsp_rdata;
                err_q   <= rsp_err;
            end
            if (dbg_req_valid_i && (state_q != IDLE)) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign dbg_req_ready_o = (state_q == IDLE);
    assign dbg_rsp_valid_o = (state_q == RESP);
    assign dbg_rsp_rdata_o = rdata_q;
    assign dbg_rsp_err_o   = err_q;
    assign bus_req_o       = (state_q == REQ);
    assign bus_we_o        = (state_q == REQ) && bus_gnt_i && we_q;
    assign bus_addr_o      = addr_q & 32'hFFFF_FFFC;
    assign bus_wdata_o     = wdata_q;
    assign ovf_o           = ovf_q;

endmodule
